// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, fetches words over a req/ack port and
// hands them to the decoder over valid/ready. Optional jal link port: IFETCH_LINK_EN.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Opcode,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] pc_out,
    input  logic        Jump,
    input  logic        Branch,
    input  logic        Zero
`ifdef IFETCH_LINK_EN
    ,
    output logic        link_we,
    output logic [31:0] link_addr
`endif
);

    localparam logic [31:0] RESET_ADDR = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic [31:0] pc;

    // Jump beats branch; both targets are relative to the word after pc_out.
    function automatic logic [31:0] next_pc(input logic [31:0] cur,
                                            input logic [31:0] op,
                                            input logic        jump,
                                            input logic        taken);
        logic [31:0] p4;
        logic [31:0] offset;
        p4     = cur + 32'd4;
        offset = {{14{op[15]}}, op[15:0], 2'b00};
        if (jump)
            return {p4[31:28], op[25:0], 2'b00};
        else if (taken)
            return p4 + offset;
        else
            return p4;
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        accept      = 1'b0;
        case (state)
            IDLE: state_nxt = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack)
                    state_nxt = HOLD;
            end
            HOLD: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    accept    = 1'b1;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Acks outside FETCH never reach Opcode; the PC only moves at an accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= RESET_ADDR;
            Opcode <= 32'h0;
            pc_out <= RESET_ADDR;
        end else begin
            if (state == FETCH && imem_ack) begin
                Opcode <= imem_rdata;
                pc_out <= pc;
            end
            if (accept)
                pc <= next_pc(pc_out, Opcode, Jump, Branch && Zero);
        end
    end

    assign imem_addr = pc;

`ifdef IFETCH_LINK_EN
    logic is_jal;
    assign is_jal = accept && Jump && (Opcode[31:26] == 6'b000011);

    always_ff @(posedge clk) begin
        if (rst) begin
            link_we   <= 1'b0;
            link_addr <= 32'h0;
        end else begin
            link_we <= is_jal;
            if (is_jal)
                link_addr <= pc_out + 32'd4;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed plus randomized bench for instr_fetch against an arithmetic PC model;
// runs with or without IFETCH_LINK_EN.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC   = 32'hFFFF_FFF3;
    localparam logic [31:0] RST_ADDR = 32'hFFFF_FFF0;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] Opcode;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc_out;
    logic        Jump;
    logic        Branch;
    logic        Zero;
`ifdef IFETCH_LINK_EN
    logic        link_we;
    logic [31:0] link_addr;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_pc;
    logic [31:0] cur_op;
    logic [31:0] cur_pc;

    instr_fetch #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .Opcode(Opcode), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .pc_out(pc_out), .Jump(Jump), .Branch(Branch), .Zero(Zero)
`ifdef IFETCH_LINK_EN
        , .link_we(link_we), .link_addr(link_addr)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Reference: next fetch address from the ISA rules using plain integer math.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] op,
                                               input logic j, input logic b, input logic z);
        longint p4;
        longint off;
        longint t;
        p4 = (longint'(pc) + 4) % 64'sh1_0000_0000;
        if (j) begin
            t = (p4 / 268435456) * 268435456 + longint'(op % 32'd67108864) * 4;
            return t[31:0];
        end
        if (b && z) begin
            off = longint'(op % 32'd65536);
            if (off >= 32768) off = off - 65536;
            t = p4 + off * 4;
            if (t < 0) t = t + 64'sh1_0000_0000;
            if (t >= 64'sh1_0000_0000) t = t - 64'sh1_0000_0000;
            return t[31:0];
        end
        return p4[31:0];
    endfunction

    task automatic check_reset_values();
        check1 ("rst_req", imem_req, 1'b0);
        check1 ("rst_valid", instr_valid, 1'b0);
        check32("rst_addr", imem_addr, RST_ADDR);
        check32("rst_opcode", Opcode, 32'h0);
        check32("rst_pc_out", pc_out, RST_ADDR);
`ifdef IFETCH_LINK_EN
        check1 ("rst_link_we", link_we, 1'b0);
        check32("rst_link_addr", link_addr, 32'h0);
`endif
    endtask

    // Entered just after the edge that moved the DUT into FETCH.
    task automatic fetch_word(input int stall, input logic [31:0] data);
        check1 ("fetch_req", imem_req, 1'b1);
        check32("fetch_addr", imem_addr, exp_pc);
        check1 ("fetch_valid_low", instr_valid, 1'b0);
        for (int i = 0; i < stall; i++) begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            tick();
            check1 ("stall_req", imem_req, 1'b1);
            check32("stall_addr", imem_addr, exp_pc);
        end
        imem_ack   = 1'b1;
        imem_rdata = data;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        check1 ("hold_valid", instr_valid, 1'b1);
        check32("hold_opcode", Opcode, data);
        check32("hold_pc_out", pc_out, exp_pc);
        check1 ("hold_req_low", imem_req, 1'b0);
`ifdef IFETCH_LINK_EN
        check1 ("link_we_idle", link_we, 1'b0);
`endif
        cur_op = data;
        cur_pc = exp_pc;
    endtask

    task automatic accept_word(input int stall, input logic j, input logic b, input logic z);
        for (int i = 0; i < stall; i++) begin
            instr_ready = 1'b0;
            Jump        = 1'($urandom);
            Branch      = 1'($urandom);
            Zero        = 1'($urandom);
            imem_ack    = 1'($urandom);
            imem_rdata  = $urandom;
            tick();
            check1 ("cstall_valid", instr_valid, 1'b1);
            check32("cstall_opcode", Opcode, cur_op);
            check32("cstall_pc_out", pc_out, cur_pc);
            check1 ("cstall_no_req", imem_req, 1'b0);
        end
        imem_ack    = 1'b0;
        instr_ready = 1'b1;
        Jump        = j;
        Branch      = b;
        Zero        = z;
        tick();
        instr_ready = 1'b0;
        Jump        = 1'($urandom);
        Branch      = 1'($urandom);
        Zero        = 1'($urandom);
        exp_pc = model_next(cur_pc, cur_op, j, b, z);
        check1 ("acc_valid_low", instr_valid, 1'b0);
        check1 ("acc_req", imem_req, 1'b1);
        check32("acc_next_addr", imem_addr, exp_pc);
`ifdef IFETCH_LINK_EN
        check1("acc_link_we", link_we, j && (cur_op[31:26] == 6'b000011));
        if (j && (cur_op[31:26] == 6'b000011))
            check32("acc_link_addr", link_addr, cur_pc + 32'd4);
`endif
    endtask

    initial begin
        logic [31:0] data;
        logic        j;
        logic        b;
        logic        z;

        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
        Jump = 1'b0; Branch = 1'b0; Zero = 1'b0;
        tick();
        tick();
        check_reset_values();

        // IDLE cycle: a stray ack must be dropped.
        rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        tick();
        imem_ack = 1'b0;
        check32("idle_ack_dropped", Opcode, 32'h0);
        exp_pc = RST_ADDR;

        // Free run from 0xFFFFFFF0 across the wrap to 0..0xC.
        for (int i = 0; i < 8; i++) begin
            fetch_word(0, 32'h2000_0000 + i);
            accept_word(0, 1'b0, 1'b0, 1'b0);
        end
        check32("wrap_addr_0x10", imem_addr, 32'h10);

        // Memory stall, then consumer stall.
        fetch_word(3, 32'hA5A5_1234);
        accept_word(4, 1'b0, 1'b0, 1'b0);

        // Jump to 0x100, branch taken back to itself, then not taken.
        fetch_word(0, 32'h0800_0040);
        accept_word(0, 1'b1, 1'b0, 1'b0);
        check32("jump_to_100", imem_addr, 32'h100);
        fetch_word(0, 32'h1000_FFFF);
        accept_word(0, 1'b0, 1'b1, 1'b1);
        check32("branch_taken", imem_addr, 32'h100);
        fetch_word(0, 32'h1000_FFFF);
        accept_word(1, 1'b0, 1'b1, 1'b0);
        check32("branch_not_taken", imem_addr, 32'h104);

        // Jumps around 0x0040_0020, including jal and jump+branch priority.
        fetch_word(0, 32'h0810_0008);
        accept_word(0, 1'b1, 1'b0, 1'b0);
        check32("jump_400020", imem_addr, 32'h0040_0020);
        fetch_word(0, 32'h0810_0004);
        accept_word(0, 1'b1, 1'b0, 1'b0);
        check32("jump_400010", imem_addr, 32'h0040_0010);
        fetch_word(2, 32'h0C10_0004);
        accept_word(0, 1'b1, 1'b0, 1'b0);
        fetch_word(0, 32'h0C00_0000);
        accept_word(0, 1'b0, 1'b0, 1'b0);
        fetch_word(0, 32'h0810_0040);
        accept_word(0, 1'b1, 1'b1, 1'b1);

        // Reset during FETCH with an ack in the same cycle.
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        rst = 1'b0; imem_ack = 1'b0;
        check_reset_values();
        tick();
        check1("post_rst_valid", instr_valid, 1'b0);
        exp_pc = RST_ADDR;
        fetch_word(1, 32'h1111_2222);
        accept_word(0, 1'b0, 1'b0, 1'b0);

        // Reset during HOLD.
        fetch_word(0, 32'h3333_4444);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_values();
        tick();
        exp_pc = RST_ADDR;

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            data = $urandom;
            if ($urandom_range(0, 3) == 0) data[31:26] = 6'b000011;
            j = ($urandom_range(0, 3) == 0);
            b = 1'($urandom);
            z = 1'($urandom);
            fetch_word($urandom_range(0, 3), data);
            accept_word($urandom_range(0, 3), j, b, z);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit that supplies 32-bit instruction words to the `CONTROL` decoder and the datapath. It owns the program counter and requests each word from instruction memory with a req/ack handshake. It presents the fetched word on `Opcode` with a valid/ready handshake. It redirects the PC from the `Jump`/`Branch` decisions that control and the ALU return for the instruction just consumed.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000, PC loaded on reset; bits [1:0] are ignored and treated as 0.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  word address of the fetch; bits [1:0] are always 0.
- `imem_ack`  in  1  memory has `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  instruction word from memory.
- `Opcode`  out  32  instruction word delivered to control and the datapath.
- `instr_valid`  out  1  `Opcode` and `pc_out` are valid.
- `instr_ready`  in  1  consumer accepts `Opcode` this cycle.
- `pc_out`  out  32  PC of the word on `Opcode`.
- `Jump`  in  1  the accepted instruction is a jump.
- `Branch`  in  1  the accepted instruction is a conditional branch.
- `Zero`  in  1  branch condition is true.

## Operation
- FSM states:
  - IDLE: entered on reset.
  - FETCH: `imem_req`=1 and `imem_addr`=pc, both held stable until `imem_ack`.
  - HOLD: `instr_valid`=1, with `Opcode`/`pc_out` stable until `instr_ready`.
- Transitions:
  - IDLE→FETCH unconditionally.
  - FETCH→HOLD on `imem_ack`; `Opcode` is captured from `imem_rdata`.
  - HOLD→FETCH on `instr_valid && instr_ready` (the accept).
- `Jump`/`Branch`/`Zero` are sampled only at the accept edge and are ignored otherwise.
- Next PC at accept, with p4 = pc_out+4:
  - `Jump`=1: {p4[31:28], Opcode[25:0], 2'b00}.
  - else `Branch`&&`Zero`: p4 + (sign_extend(Opcode[15:0]) << 2), with wrap modulo 2^32.
  - else p4, with wrap from 32'hFFFF_FFFC to 0.
  - `Jump` has priority over `Branch` when both are set.
- No branch delay slot. No jump-register support (jr is out of scope).
- `imem_ack` in IDLE or HOLD is ignored and the data is dropped.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=RESET_PC, `instr_valid`=0.
  - `Opcode`=32'h0, `pc_out`=RESET_PC.
  - state=IDLE.
- `rst` asserted mid-fetch or mid-hold: the next edge forces the reset values. A pending ack is discarded and the request is abandoned.
- First cycle after `rst` deasserts: IDLE. `imem_req` rises on the following edge.
- `imem_ack` may arrive in the first FETCH cycle. `instr_valid` rises at the edge after the ack edge.
- `instr_ready` high in the first HOLD cycle: `imem_req` for the next PC rises at the edge after the accept.
- Peak throughput is 1 instruction per 2 cycles (zero-wait memory and always-ready consumer).
- `instr_valid` never drops without an accept. `imem_req` never drops without an ack (except on reset).

## Configuration
- `IFETCH_LINK_EN` defined:
  - Adds outputs `link_we` (1) and `link_addr` (32).
  - At the accept of an instruction with `Jump`=1 and `Opcode[31:26]`=6'b000011 (jal), `link_we` pulses high for exactly one cycle, with `link_addr`=pc_out+4.
  - Reset values: `link_we`=0, `link_addr`=0.
- Undefined:
  - The ports do not exist.
  - jal behaves exactly as a plain jump.

## Test plan
- Reset then free run with zero-wait memory: `imem_addr` sequence is 0, 4, 8, 12 (RESET_PC=0); `instr_valid` rises every 2 cycles; `pc_out` tracks each word.
- Memory stall of 3 cycles before ack: `imem_req` and `imem_addr`=0x10 stay stable across the stall; `Opcode` equals `imem_rdata` from the ack cycle.
- Consumer stall with `instr_ready` low for 4 cycles: `Opcode`, `pc_out` and `instr_valid` stay stable; no new `imem_req` is issued.
- Branch taken: pc_out=0x100, `Opcode[15:0]`=16'hFFFF, `Branch`=`Zero`=1 at accept → next `imem_addr`=0x100. With `Zero`=0 → next `imem_addr`=0x104.
- Jump: pc_out=0x0040_0020, `Opcode`=32'h0810_0004 with `Jump`=1 → next `imem_addr`=0x0040_0010. With `IFETCH_LINK_EN` and opcode 000011, `link_we` pulses once with `link_addr`=0x0040_0024.
- `rst` pulsed during FETCH with ack arriving the same cycle: the data is not delivered; after reset, `imem_addr`=RESET_PC and `instr_valid` stays 0 until the new fetch completes.
